// File: rtl/reg_access_ctrl.sv
// reg_access_ctrl: sequences two reads, an operand offer and an optional write-back on a single-port register file.
// Ports: clock/reset (async, active-high); req_* request handshake and fields; rf_* register file port
// (registered read, 1-cycle latency); op_* operand handshake to execute; res_* result handshake; busy.
module reg_access_ctrl #(
    parameter int BIT = 8,
    parameter int SZB = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [SZB-1:0] req_rs1,
    input  logic [SZB-1:0] req_rs2,
    input  logic [SZB-1:0] req_rd,
    input  logic           req_wb,
    output logic           rf_we,
    output logic [SZB-1:0] rf_addr,
    output logic [BIT-1:0] rf_din,
    input  logic [BIT-1:0] rf_dout,
    output logic           op_valid,
    input  logic           op_ready,
    output logic [BIT-1:0] op_a,
    output logic [BIT-1:0] op_b,
    output logic           res_ready,
    input  logic           res_valid,
    input  logic [BIT-1:0] res_data,
    output logic           busy
);
    typedef enum logic [2:0] {IDLE, RD_A, RD_B, CAP_B, OFFER, WAIT_WB, WRITE} state_t;
    state_t         state_q, state_d;
    logic [SZB-1:0] rs1_q, rs2_q, rd_q;
    logic           wb_q;
    logic [BIT-1:0] op_a_q, op_b_q, res_q;
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = req_valid ? RD_A : IDLE;
            RD_A:    state_d = RD_B;
            RD_B:    state_d = CAP_B;
            CAP_B:   state_d = OFFER;
            OFFER:   state_d = op_ready ? (wb_q ? WAIT_WB : IDLE) : OFFER;
            WAIT_WB: state_d = res_valid ? WRITE : WAIT_WB;
            default: state_d = IDLE;
        endcase
    end
    // rs1 data arrives while rs2 is being addressed, so op_a is captured in RD_B and op_b one cycle later
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            wb_q    <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid) begin
                rs1_q <= req_rs1;
                rs2_q <= req_rs2;
                rd_q  <= req_rd;
                wb_q  <= req_wb;
            end
            if (state_q == RD_B) op_a_q <= rf_dout;
            if (state_q == CAP_B) op_b_q <= rf_dout;
            if (state_q == WAIT_WB && res_valid) res_q <= res_data;
        end
    end
    assign req_ready = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign op_valid  = state_q == OFFER;
    assign res_ready = state_q == WAIT_WB;
    assign rf_we     = state_q == WRITE;
    assign rf_din    = rf_we ? res_q : '0;
    assign rf_addr   = state_q == RD_A  ? rs1_q :
                       state_q == RD_B  ? rs2_q :
                       state_q == WRITE ? rd_q  : '0;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
endmodule

// File: tb/tb_reg_access_ctrl.sv
// tb_reg_access_ctrl: scoreboard bench for reg_access_ctrl with a behavioural single-port register file.
module tb_reg_access_ctrl;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0, req_ready, req_wb = 1'b0;
    logic [3:0] req_rs1 = '0, req_rs2 = '0, req_rd = '0;
    logic       rf_we;
    logic [3:0] rf_addr;
    logic [7:0] rf_din, rf_dout = '0;
    logic       op_valid, op_ready = 1'b0;
    logic [7:0] op_a, op_b;
    logic       res_ready, res_valid = 1'b0;
    logic [7:0] res_data = '0;
    logic       busy;
    logic [7:0] mem [16] = '{default: 8'h00};
    logic       pl_we = 1'b0;
    logic [3:0] pl_addr = '0;
    logic [7:0] pl_data = '0;
    logic [15:0] opq[$];
    logic [11:0] wq[$];
    int pass_cnt = 0, total_cnt = 0, hs = 0;
    reg_access_ctrl #(.BIT(8), .SZB(4)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .req_wb(req_wb),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_din(rf_din), .rf_dout(rf_dout),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .res_ready(res_ready), .res_valid(res_valid), .res_data(res_data),
        .busy(busy)
    );
    always #5 clock = ~clock;
    always @(posedge clock) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        else if (rf_we) mem[rf_addr] <= rf_din;
        else rf_dout <= mem[rf_addr];
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    always @(negedge clock) begin
        if (!reset) begin
            if (op_valid && op_ready) begin
                hs++;
                if (opq.size() > 0) begin
                    logic [15:0] e;
                    e = opq.pop_front();
                    check("op_a", {24'd0, op_a}, {24'd0, e[15:8]});
                    check("op_b", {24'd0, op_b}, {24'd0, e[7:0]});
                end else check("op_unexpected", 1, 0);
            end
            if (rf_we) begin
                if (wq.size() > 0) begin
                    logic [11:0] w;
                    w = wq.pop_front();
                    check("wr_addr", {28'd0, rf_addr}, {28'd0, w[11:8]});
                    check("wr_data", {24'd0, rf_din}, {24'd0, w[7:0]});
                end else check("wr_unexpected", 1, 0);
            end
        end
    end
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    task automatic preload(input logic [3:0] a, input logic [7:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_we = 1'b0;
    endtask
    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d, input logic w);
        int n = 0;
        while (!req_ready && n < 50) begin tick(); n++; end
        check("req_ready_timeout", {31'd0, n < 50}, 1);
        req_rs1 = a; req_rs2 = b; req_rd = d; req_wb = w; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask
    task automatic wait_ov(output int n);
        n = 0;
        while (!op_valid && n < 20) begin tick(); n++; end
        check("op_valid_timeout", {31'd0, n < 20}, 1);
    endtask
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d, input logic w,
                          input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] res, input int hold);
        int n, h0;
        opq.push_back({ea, eb});
        if (w) wq.push_back({d, res});
        issue(a, b, d, w);
        wait_ov(n);
        check("op_latency", n, 3);
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", {31'd0, op_valid}, 1);
            check("hold_a", {24'd0, op_a}, {24'd0, ea});
            check("hold_b", {24'd0, op_b}, {24'd0, eb});
            check("hold_we", {31'd0, rf_we}, 0);
            tick();
        end
        h0 = hs;
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        check("one_handshake", hs - h0, 1);
        if (w) begin
            check("res_ready", {31'd0, res_ready}, 1);
            res_valid = 1'b1; res_data = res;
            tick();
            res_valid = 1'b0;
            check("write_pulse", {31'd0, rf_we}, 1);
            tick();
            check("write_once", {31'd0, rf_we}, 0);
        end
        check("back_idle", {31'd0, req_ready}, 1);
        check("held_a", {24'd0, op_a}, {24'd0, ea});
    endtask
    initial begin
        int n;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        check("rst_req_ready", {31'd0, req_ready}, 1);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_op_valid", {31'd0, op_valid}, 0);
        check("rst_we", {31'd0, rf_we}, 0);
        check("rst_op_a", {24'd0, op_a}, 0);
        // registers at power-on values, no write-back
        run_op(4'd2, 4'd3, 4'd0, 1'b0, 8'h00, 8'h00, 8'h00, 0);
        // preloaded operands with write-back to r1, then read r1 back
        preload(4'd5, 8'h3C);
        preload(4'd9, 8'hA1);
        run_op(4'd5, 4'd9, 4'd1, 1'b1, 8'h3C, 8'hA1, 8'hDD, 0);
        run_op(4'd1, 4'd1, 4'd0, 1'b0, 8'hDD, 8'hDD, 8'h00, 0);
        // execute stage stalls 5 cycles
        run_op(4'd9, 4'd5, 4'd3, 1'b0, 8'hA1, 8'h3C, 8'h00, 5);
        // rs1 == rs2 == rd, then the same request sees the written value
        preload(4'd7, 8'h10);
        run_op(4'd7, 4'd7, 4'd7, 1'b1, 8'h10, 8'h10, 8'h20, 0);
        run_op(4'd7, 4'd7, 4'd7, 1'b0, 8'h20, 8'h20, 8'h00, 0);
        // register 0 is an ordinary register
        run_op(4'd7, 4'd1, 4'd0, 1'b1, 8'h20, 8'hDD, 8'h99, 0);
        run_op(4'd0, 4'd0, 4'd0, 1'b0, 8'h99, 8'h99, 8'h00, 0);
        // reset in WAIT_WB together with res_valid
        preload(4'd4, 8'h11);
        preload(4'd6, 8'h22);
        opq.push_back({8'h11, 8'h22});
        issue(4'd4, 4'd6, 4'd2, 1'b1);
        wait_ov(n);
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        check("wb_res_ready", {31'd0, res_ready}, 1);
        res_valid = 1'b1; res_data = 8'h55;
        #2 reset = 1'b1;
        #1;
        check("arst_we", {31'd0, rf_we}, 0);
        check("arst_req_ready", {31'd0, req_ready}, 1);
        check("arst_op_a", {24'd0, op_a}, 0);
        check("arst_op_b", {24'd0, op_b}, 0);
        tick();
        res_valid = 1'b0;
        reset = 1'b0;
        tick();
        check("post_rst_ready", {31'd0, req_ready}, 1);
        check("post_rst_we", {31'd0, rf_we}, 0);
        check("r2_untouched", {24'd0, mem[2]}, 0);
        // stray req_valid and res_valid while in RD_B
        preload(4'd10, 8'h5A);
        preload(4'd11, 8'hA5);
        opq.push_back({8'h5A, 8'hA5});
        wq.push_back({4'd12, 8'h77});
        issue(4'd10, 4'd11, 4'd12, 1'b1);
        tick();
        check("rdb_busy", {31'd0, busy}, 1);
        req_rs1 = 4'd5; req_rs2 = 4'd9; req_rd = 4'd13; req_wb = 1'b1; req_valid = 1'b1;
        res_valid = 1'b1; res_data = 8'hEE;
        tick();
        req_valid = 1'b0;
        res_valid = 1'b0;
        wait_ov(n);
        check("stray_latency", n, 1);
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        check("stray_res_ready", {31'd0, res_ready}, 1);
        res_valid = 1'b1; res_data = 8'h77;
        tick();
        res_valid = 1'b0;
        tick();
        check("stray_idle", {31'd0, req_ready}, 1);
        tick();
        check("stray_not_accepted", {31'd0, busy}, 0);
        check("r12_written", {24'd0, mem[12]}, 32'h77);
        check("r13_untouched", {24'd0, mem[13]}, 0);
        check("opq_drained", opq.size(), 0);
        check("wq_drained", wq.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
